keypad_encoder: RTL and testbench

//   Downstream of the per-key debouncers. Consumes 10 debounced key lines (digits 0-9).

---
 rtl/keypad_encoder_pkg.sv | 14 +
 rtl/keypad_encoder_if.sv | 29 ++
 rtl/keypad_encoder_onehot_to_bcd.sv | 28 ++
 rtl/keypad_encoder.sv | 143 ++++++++++++++
 tb/tb_keypad_encoder.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/keypad_encoder_pkg.sv
// Shared constants and FSM state type for the keypad encoder.
package keypad_encoder_pkg;

    localparam int unsigned KEY_W        = 10;
    localparam int unsigned BCD_W        = 4;
    localparam int unsigned ENTRY_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } kp_state_e;

endpackage

// File: rtl/keypad_encoder_if.sv
// Key input / encoded output bundle between the key front end and the entry logic.
interface keypad_encoder_if
    import keypad_encoder_pkg::*;
#(
    parameter int unsigned NKEYS      = KEY_W,
    parameter int unsigned MAX_DIGITS = ENTRY_DIGITS
);
    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

    logic [NKEYS-1:0]          key_db;
    logic                      clear_entry;
    logic [BCD_W-1:0]          bcd;
    logic                      key_valid;
    logic [4*MAX_DIGITS-1:0]   digits;
    logic [CNT_W-1:0]          digit_count;
    logic                      entry_full;
    logic                      multi_key_err;

    modport master (
        output key_db, clear_entry,
        input  bcd, key_valid, digits, digit_count, entry_full, multi_key_err
    );

    modport slave (
        input  key_db, clear_entry,
        output bcd, key_valid, digits, digit_count, entry_full, multi_key_err
    );

endinterface

// File: rtl/keypad_encoder_onehot_to_bcd.sv
// Combinational key-vector decoder: index of the set bit and a one-hot flag.
module onehot_to_bcd
    import keypad_encoder_pkg::*;
#(
    parameter int unsigned NKEYS = KEY_W
) (
    input  logic [NKEYS-1:0] i_vec,
    output logic [BCD_W-1:0] o_bcd,
    output logic             o_is_onehot
);
    localparam int unsigned POP_W = $clog2(NKEYS + 1);

    logic [POP_W-1:0] w_pop;

    // Index of the highest set bit plus population count; index only meaningful when one-hot.
    always_comb begin
        o_bcd = '0;
        w_pop = '0;
        for (int unsigned i = 0; i < NKEYS; i++) begin
            if (i_vec[i]) begin
                o_bcd = BCD_W'(i);
            end
            w_pop = w_pop + POP_W'(i_vec[i]);
        end
        o_is_onehot = (w_pop == POP_W'(1));
    end

endmodule

// File: rtl/keypad_encoder.sv
// Keypad encoder: press qualification FSM, BCD strobe and digit entry register.
module keypad_encoder
    import keypad_encoder_pkg::*;
#(
    parameter int unsigned NKEYS      = KEY_W,
    parameter int unsigned MAX_DIGITS = ENTRY_DIGITS
) (
    input  logic            clk,
    input  logic            rst_n,
    keypad_encoder_if.slave kp
);
    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int unsigned DIG_W = 4 * MAX_DIGITS;

    kp_state_e          r_state;
    kp_state_e          w_next;
    logic [NKEYS-1:0]   r_cap;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_valid;
    logic               r_err;
    logic [DIG_W-1:0]   r_digits;
    logic [CNT_W-1:0]   r_count;
    logic               r_full;

    logic [BCD_W-1:0]   w_cap_bcd;
    logic               w_cap_onehot;
    logic               w_cap_multi;
    logic               w_capture;
    logic               w_accept;
    logic               w_reject;
    logic               w_err_clr;
    logic [DIG_W-1:0]   w_digits_nx;
    logic [CNT_W-1:0]   w_count_nx;

    onehot_to_bcd #(.NKEYS(NKEYS)) u_dec (
        .i_vec       (r_cap),
        .o_bcd       (w_cap_bcd),
        .o_is_onehot (w_cap_onehot)
    );

    assign w_cap_multi = !w_cap_onehot && (r_cap != '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and press qualification decisions.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_accept  = 1'b0;
        w_reject  = 1'b0;
        w_err_clr = 1'b0;
        case (r_state)
            IDLE: begin
                if (kp.key_db != '0) begin
                    w_capture = 1'b1;
                    w_next    = SETTLE;
                end
            end
            SETTLE: begin
                if (kp.key_db == '0) begin
                    w_next = IDLE;
                end else if ((kp.key_db == r_cap) && !w_cap_multi) begin
                    w_accept = 1'b1;
                    w_next   = HELD;
                end else begin
                    w_reject = 1'b1;
                    w_next   = HELD;
                end
            end
            HELD: begin
                if (kp.key_db == '0) begin
                    w_err_clr = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Captured key, BCD code, one-cycle strobe and multi-key flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap   <= '0;
            r_bcd   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_accept;
            if (w_capture) begin
                r_cap <= kp.key_db;
            end
            if (w_accept) begin
                r_bcd <= w_cap_bcd;
            end
            if (w_reject) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // Entry register next value: clear wins over an accept; a full register holds.
    always_comb begin
        w_digits_nx = r_digits;
        w_count_nx  = r_count;
        if (kp.clear_entry) begin
            w_digits_nx = '0;
            w_count_nx  = '0;
        end else if (w_accept && (r_count < CNT_W'(MAX_DIGITS))) begin
            w_digits_nx = {r_digits[DIG_W-5:0], w_cap_bcd};
            w_count_nx  = r_count + CNT_W'(1);
        end
    end

    // Entry register, digit count and full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            r_digits <= w_digits_nx;
            r_count  <= w_count_nx;
            r_full   <= (w_count_nx == CNT_W'(MAX_DIGITS));
        end
    end

    assign kp.bcd           = r_bcd;
    assign kp.key_valid     = r_valid;
    assign kp.digits        = r_digits;
    assign kp.digit_count   = r_count;
    assign kp.entry_full    = r_full;
    assign kp.multi_key_err = r_err;

endmodule

// File: tb/tb_keypad_encoder.sv
// Scoreboard bench for keypad_encoder: expected strobes queued by stimulus, checked by a monitor.
module tb_keypad_encoder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int          cyc;
        logic [3:0]  bcd;
        logic [15:0] digits;
        logic [2:0]  count;
        logic        full;
    } exp_t;

    exp_t exp_q[$];

    keypad_encoder_if #(.NKEYS(10), .MAX_DIGITS(4)) ifc ();

    keypad_encoder #(.NKEYS(10), .MAX_DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (ifc.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    exp_t e;
    always @(negedge clk) begin
        if (ifc.key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_cycle", cyc, e.cyc);
                check("strobe_bcd", ifc.bcd, e.bcd);
                check("strobe_digits", ifc.digits, e.digits);
                check("strobe_count", ifc.digit_count, e.count);
                check("strobe_full", ifc.entry_full, e.full);
            end
        end
    end

    task automatic push(input int c, input logic [3:0] b, input logic [15:0] d,
                        input logic [2:0] n, input logic f);
        exp_t x;
        x.cyc = c; x.bcd = b; x.digits = d; x.count = n; x.full = f;
        exp_q.push_back(x);
    endtask

    task automatic press(input logic [9:0] key, input int hold, input bit accept,
                         input logic [3:0] b, input logic [15:0] d,
                         input logic [2:0] n, input logic f);
        @(posedge clk); #1;
        ifc.key_db = key;
        if (accept) push(cyc + 2, b, d, n, f);
        repeat (hold) @(posedge clk);
        #1 ifc.key_db = '0;
        repeat (3) @(posedge clk);
    endtask

    task automatic clear_pulse();
        @(posedge clk); #1 ifc.clear_entry = 1'b1;
        @(posedge clk); #1 ifc.clear_entry = 1'b0;
        check("clear_digits", ifc.digits, 16'h0000);
        check("clear_count", ifc.digit_count, 3'd0);
        check("clear_full", ifc.entry_full, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bcd"}, ifc.bcd, 4'd0);
        check({tag, "_valid"}, ifc.key_valid, 1'b0);
        check({tag, "_digits"}, ifc.digits, 16'h0000);
        check({tag, "_count"}, ifc.digit_count, 3'd0);
        check({tag, "_full"}, ifc.entry_full, 1'b0);
        check({tag, "_err"}, ifc.multi_key_err, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        ifc.key_db      = '0;
        ifc.clear_entry = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: single press of key 7, long hold
        press(10'h080, 20, 1'b1, 4'd7, 16'h0007, 3'd1, 1'b0);
        check("t1_digits", ifc.digits, 16'h0007);
        check("t1_count", ifc.digit_count, 3'd1);

        // 2: fill entry with 1,2,3,0 then one press beyond full
        clear_pulse();
        press(10'h002, 4, 1'b1, 4'd1, 16'h0001, 3'd1, 1'b0);
        press(10'h004, 4, 1'b1, 4'd2, 16'h0012, 3'd2, 1'b0);
        press(10'h008, 4, 1'b1, 4'd3, 16'h0123, 3'd3, 1'b0);
        press(10'h001, 4, 1'b1, 4'd0, 16'h1230, 3'd4, 1'b1);
        press(10'h200, 4, 1'b1, 4'd9, 16'h1230, 3'd4, 1'b1);
        check("t2_full", ifc.entry_full, 1'b1);

        // 3: one-cycle glitch, no strobe
        press(10'h004, 1, 1'b0, 4'd0, 16'h0000, 3'd0, 1'b0);
        check("t3_digits", ifc.digits, 16'h1230);
        check("t3_err", ifc.multi_key_err, 1'b0);

        // 4: two keys held together
        @(posedge clk); #1 ifc.key_db = 10'h006;
        @(posedge clk);
        @(posedge clk); #1;
        check("t4_err_e1", ifc.multi_key_err, 1'b1);
        repeat (5) @(posedge clk); #1;
        check("t4_err_held", ifc.multi_key_err, 1'b1);
        ifc.key_db = '0;
        #1 check("t4_err_before_edge", ifc.multi_key_err, 1'b1);
        @(posedge clk); #1;
        check("t4_err_cleared", ifc.multi_key_err, 1'b0);
        check("t4_digits", ifc.digits, 16'h1230);
        check("t4_count", ifc.digit_count, 3'd4);

        // 5: clear_entry coincides with accept of key 5
        clear_pulse();
        press(10'h002, 4, 1'b1, 4'd1, 16'h0001, 3'd1, 1'b0);
        press(10'h004, 4, 1'b1, 4'd2, 16'h0012, 3'd2, 1'b0);
        check("t5_pre_digits", ifc.digits, 16'h0012);
        @(posedge clk); #1 ifc.key_db = 10'h020;
        push(cyc + 2, 4'd5, 16'h0000, 3'd0, 1'b0);
        @(posedge clk); #1 ifc.clear_entry = 1'b1;
        @(posedge clk); #1 ifc.clear_entry = 1'b0;
        check("t5_digits", ifc.digits, 16'h0000);
        check("t5_count", ifc.digit_count, 3'd0);
        repeat (3) @(posedge clk); #1 ifc.key_db = '0;
        repeat (3) @(posedge clk);

        // 6: async reset while holding a key, key still held after release
        press(10'h010, 4, 1'b1, 4'd4, 16'h0004, 3'd1, 1'b0);
        @(posedge clk); #1 ifc.key_db = 10'h004;
        push(cyc + 2, 4'd2, 16'h0042, 3'd2, 1'b0);
        repeat (5) @(posedge clk);
        check("t6_pre_digits", ifc.digits, 16'h0042);
        @(posedge clk); #2 rst_n = 1'b0;
        #1 check_all_zero("t6_async");
        repeat (2) @(posedge clk); #1;
        push(cyc + 2, 4'd2, 16'h0002, 3'd1, 1'b0);
        rst_n = 1'b1;
        repeat (6) @(posedge clk); #1 ifc.key_db = '0;
        repeat (5) @(posedge clk);

        check("pending_strobes", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
